// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - pipelined Wishbone burst master with outstanding limit and ack timeout
module wb_burst_master #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] TIMEOUT         = 32'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_len,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_data_w,
  output logic        wb_we,
  output logic        wb_stb,
  output logic        wb_cyc,
  input  logic [31:0] wb_data_r,
  input  logic        wb_ack,
  input  logic        wb_stall
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [4:0] MAX_OUT = 5'(MAX_OUTSTANDING);

  state_t      state;
  logic [4:0]  beats;
  logic [4:0]  issued;
  logic [4:0]  acked;
  logic [4:0]  outstanding;
  logic [31:0] tmo_cnt;

  logic        issue;
  logic        ack_cnt;
  logic        last_ack;
  logic        tmo_hit;
  logic [4:0]  issued_n;
  logic [4:0]  outst_n;

  assign cmd_ready = (state == IDLE);

  // Acks with nothing in flight are stray and never reach the counters.
  always_comb begin
    issue    = wb_stb && !wb_stall;
    ack_cnt  = wb_ack && (outstanding != 5'd0);
    issued_n = issued + {4'd0, issue};
    outst_n  = outstanding + {4'd0, issue} - {4'd0, ack_cnt};
    last_ack = ack_cnt && ((acked + 5'd1) == beats);
    tmo_hit  = !ack_cnt && ((tmo_cnt + 32'd1) == TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beats       <= '0;
      issued      <= '0;
      acked       <= '0;
      outstanding <= '0;
      tmo_cnt     <= '0;
      wb_addr     <= '0;
      wb_data_w   <= '0;
      wb_we       <= 1'b0;
      wb_stb      <= 1'b0;
      wb_cyc      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_last    <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state       <= ISSUE;
            beats       <= {1'b0, cmd_len} + 5'd1;
            issued      <= '0;
            acked       <= '0;
            outstanding <= '0;
            tmo_cnt     <= '0;
            wb_addr     <= cmd_addr;
            wb_data_w   <= cmd_data;
            wb_we       <= cmd_we;
            wb_cyc      <= 1'b1;
            wb_stb      <= 1'b1;
          end
        end
        default: begin
          if (ack_cnt) begin
            rsp_valid <= 1'b1;
            rsp_data  <= wb_we ? 32'd0 : wb_data_r;
          end
          if (last_ack) begin
            rsp_last    <= 1'b1;
            state       <= IDLE;
            wb_cyc      <= 1'b0;
            wb_stb      <= 1'b0;
            outstanding <= '0;
          end else if (tmo_hit) begin
            // Abort abandons anything still in flight; late acks become stray.
            rsp_valid   <= 1'b1;
            rsp_data    <= '0;
            rsp_last    <= 1'b1;
            rsp_err     <= 1'b1;
            state       <= IDLE;
            wb_cyc      <= 1'b0;
            wb_stb      <= 1'b0;
            outstanding <= '0;
            tmo_cnt     <= '0;
          end else begin
            issued      <= issued_n;
            outstanding <= outst_n;
            acked       <= acked + {4'd0, ack_cnt};
            tmo_cnt     <= ack_cnt ? 32'd0 : tmo_cnt + 32'd1;
            if (issue) begin
              wb_addr <= wb_addr + 32'd4;
              if (wb_we) begin
                wb_data_w <= wb_data_w + 32'd1;
              end
            end
            wb_stb <= (issued_n < beats) && (outst_n < MAX_OUT);
            state  <= (issued_n == beats) ? DRAIN : ISSUE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// tb/tb_wb_burst_master.sv - directed self-checking bench for wb_burst_master
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_we;
  logic [3:0]  cmd_len;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic [31:0] wb_addr;
  logic [31:0] wb_data_w;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_cyc;
  logic [31:0] wb_data_r;
  logic        wb_ack;
  logic        wb_stall;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] iss_addr[$];
  logic [31:0] iss_data[$];
  logic [31:0] rsp_d[$];
  logic        rsp_l[$];
  logic        rsp_e[$];
  int          seq_err;
  int          proto_err;
  int          max_out;
  int          last_cyc;
  logic        ready_last;
  logic        done;

  always #5 clk = ~clk;

  wb_burst_master #(.MAX_OUTSTANDING(2), .TIMEOUT(32'd8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_we(cmd_we), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .wb_addr(wb_addr), .wb_data_w(wb_data_w), .wb_we(wb_we), .wb_stb(wb_stb),
    .wb_cyc(wb_cyc), .wb_data_r(wb_data_r), .wb_ack(wb_ack), .wb_stall(wb_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Responder model: acks in order ack_lat cycles after issue (-1 = never),
  // stalls beat stall_beat for stall_len cycles. Cycle k = sample after k-th edge past accept.
  task automatic run_cmd(input logic [31:0] addr, input logic [31:0] data, input logic we,
                         input logic [3:0] len, input int ack_lat, input int stall_beat,
                         input int stall_len, input logic [31:0] rd_base);
    int pend[$];
    int n_iss;
    int outst;
    int ack_idx;
    int stall_left;
    logic seen_cyc;
    iss_addr.delete(); iss_data.delete();
    rsp_d.delete(); rsp_l.delete(); rsp_e.delete();
    seq_err = 0; proto_err = 0; max_out = 0; last_cyc = -1;
    ready_last = 1'b0; done = 1'b0; seen_cyc = 1'b0;
    n_iss = 0; outst = 0; ack_idx = 0; stall_left = stall_len;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_data = data; cmd_we = we; cmd_len = len;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (rsp_valid) begin
        rsp_d.push_back(rsp_data);
        rsp_l.push_back(rsp_last);
        rsp_e.push_back(rsp_err);
        if (rsp_last) begin
          done = 1'b1;
          last_cyc = k;
          ready_last = cmd_ready;
        end
      end
      if (wb_stb && !wb_cyc) proto_err++;
      if (seen_cyc && !wb_cyc && !done) proto_err++;
      if (wb_cyc) seen_cyc = 1'b1;
      if (wb_cyc && wb_we !== we) proto_err++;
      if (wb_stb && (wb_addr !== addr + 32'(4 * n_iss) ||
                     (we && wb_data_w !== data + 32'(n_iss)))) seq_err++;
      if (outst > max_out) max_out = outst;
      wb_stall = wb_stb && (n_iss == stall_beat) && (stall_left > 0);
      if (wb_stall) stall_left--;
      wb_ack = (ack_lat >= 0) && (pend.size() > 0) && (pend[0] <= k);
      wb_data_r = wb_ack ? rd_base + 32'(ack_idx) : 32'd0;
      if (wb_ack) begin
        void'(pend.pop_front());
        outst--;
        ack_idx++;
      end
      if (wb_stb && !wb_stall) begin
        iss_addr.push_back(wb_addr);
        iss_data.push_back(wb_data_w);
        pend.push_back(k + ack_lat);
        n_iss++;
        outst++;
      end
    end
    wb_ack = 1'b0;
    wb_stall = 1'b0;
    wb_data_r = 32'd0;
    check("cmd_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [3:0] lv;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_we = 1'b0; cmd_len = '0;
    wb_data_r = '0; wb_ack = 1'b0; wb_stall = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    check("rst_stb", {31'd0, wb_stb}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_addr", wb_addr, 32'd0);
    rst = 1'b0;

    // Single read, ack two cycles after stb
    run_cmd(32'h100, 32'h0, 1'b0, 4'd0, 2, -1, 0, 32'hDEADBEEF);
    check("rd1_count", rsp_d.size(), 32'd1);
    check("rd1_addr", iss_addr[0], 32'h100);
    check("rd1_data", rsp_d[0], 32'hDEADBEEF);
    check("rd1_last", {31'd0, rsp_l[0]}, 32'd1);
    check("rd1_err", {31'd0, rsp_e[0]}, 32'd0);
    check("rd1_ready_last", {31'd0, ready_last}, 32'd1);
    check("rd1_cycle", last_cyc, 32'd3);

    // Write burst of 4, ack one cycle after issue
    run_cmd(32'h0, 32'h10, 1'b1, 4'd3, 1, -1, 0, 32'h0);
    check("wr4_issued", iss_addr.size(), 32'd4);
    check("wr4_seq", seq_err, 32'd0);
    check("wr4_proto", proto_err, 32'd0);
    if (iss_addr.size() == 4) begin
      check("wr4_addr3", iss_addr[3], 32'hC);
      check("wr4_data3", iss_data[3], 32'h13);
    end
    check("wr4_count", rsp_d.size(), 32'd4);
    if (rsp_d.size() == 4) begin
      for (int i = 0; i < 4; i++) lv[i] = rsp_l[i];
      check("wr4_last_flags", {28'd0, lv}, 32'h8);
      check("wr4_rsp_data", rsp_d[1], 32'd0);
    end
    check("wr4_cycle", last_cyc, 32'd5);

    // Stall beat 1 for three cycles
    run_cmd(32'h40, 32'hA0, 1'b1, 4'd2, 1, 1, 3, 32'h0);
    check("stall_seq", seq_err, 32'd0);
    check("stall_count", rsp_d.size(), 32'd3);
    check("stall_issued", iss_addr.size(), 32'd3);
    check("stall_cycle", last_cyc, 32'd7);

    // Outstanding limit with delayed acks
    run_cmd(32'h1000, 32'h0, 1'b0, 4'd7, 4, -1, 0, 32'h5000);
    check("outst_max", max_out, 32'd2);
    check("outst_count", rsp_d.size(), 32'd8);
    check("outst_seq", seq_err, 32'd0);
    check("outst_proto", proto_err, 32'd0);
    if (rsp_d.size() == 8) check("outst_data7", rsp_d[7], 32'h5007);

    // Timeout with no acks
    run_cmd(32'h2000, 32'h0, 1'b0, 4'd1, -1, -1, 0, 32'h9000);
    check("tmo_count", rsp_d.size(), 32'd1);
    check("tmo_err", {31'd0, rsp_e[0]}, 32'd1);
    check("tmo_last", {31'd0, rsp_l[0]}, 32'd1);
    check("tmo_data", rsp_d[0], 32'd0);
    check("tmo_cycle", last_cyc, 32'd8);
    check("tmo_cyc_low", {31'd0, wb_cyc}, 32'd0);

    // Reset mid-burst, then stray ack, then a clean command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h200; cmd_data = 32'h50; cmd_we = 1'b1; cmd_len = 4'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_stb_low", {31'd0, wb_stb}, 32'd0);
    check("mid_addr", wb_addr, 32'h208);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_cyc", {31'd0, wb_cyc}, 32'd0);
    check("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    wb_ack = 1'b1; wb_data_r = 32'h1234;
    @(negedge clk);
    wb_ack = 1'b0; wb_data_r = 32'd0;
    check("stray_rsp0", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("stray_rsp1", {31'd0, rsp_valid}, 32'd0);
    run_cmd(32'h300, 32'h0, 1'b0, 4'd1, 1, -1, 0, 32'h7000);
    check("post_addr0", iss_addr[0], 32'h300);
    check("post_count", rsp_d.size(), 32'd2);
    if (rsp_d.size() == 2) check("post_data1", rsp_d[1], 32'h7001);
    check("post_seq", seq_err, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, max in-flight Wishbone requests (1..15).
REQ-002 SHALL have parameter TIMEOUT, default 32'd64, cycles without ack before abort.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_addr  input  32  first beat address.
REQ-008 cmd_data  input  32  first beat write data.
REQ-009 cmd_we  input  1  1 = write burst, 0 = read burst.
REQ-010 cmd_len  input  4  beat count minus one (0 -> 1 beat, 15 -> 16 beats).
REQ-011 rsp_valid  output  1  one-cycle pulse per completed beat or per abort; no backpressure.
REQ-012 rsp_data  output  32  read data for read beats; 0 for write beats and aborts.
REQ-013 rsp_last  output  1  final response of the command.
REQ-014 rsp_err  output  1  timeout abort indication.
REQ-015 wb_addr, wb_data_w  output  32 each  pipelined Wishbone request address/data.
REQ-016 wb_we, wb_stb, wb_cyc  output  1 each  Wishbone request controls.
REQ-017 wb_data_r  input  32; wb_ack, wb_stall  input  1 each  Wishbone responder signals.

Function
REQ-018 SHALL implement states IDLE, ISSUE, DRAIN; cmd_ready = (state == IDLE), combinational.
REQ-019 On command accept: latch addr/data/we/len, go to ISSUE; next cycle wb_cyc=1, wb_stb=1, wb_addr=cmd_addr.
REQ-020 A beat is issued on a cycle with wb_stb && !wb_stall; then wb_addr += 4 and, for writes, wb_data_w += 1 (32-bit wrap).
REQ-021 While wb_stall is high, wb_addr, wb_data_w, wb_we, wb_stb SHALL hold unchanged.
REQ-022 wb_stb SHALL be high only while issued < len+1 and outstanding < MAX_OUTSTANDING, evaluated on registered state (no combinational path from wb_ack/wb_stall to wb_stb).
REQ-023 outstanding SHALL update as outstanding + (beat issued) - (wb_ack && outstanding > 0); simultaneous issue and ack leave it unchanged.
REQ-024 wb_ack while outstanding == 0 SHALL be ignored (no response, no counter change).
REQ-025 After the last beat is issued, state SHALL be DRAIN with wb_stb=0, wb_cyc=1.
REQ-026 Each counted ack SHALL produce rsp_valid on the next cycle with rsp_data = registered wb_data_r (reads) or 0 (writes), rsp_err=0.
REQ-027 rsp_last SHALL be set on the response for the (len+1)-th ack; the same edge drives wb_cyc=0 and state IDLE, so cmd_ready is high in that cycle.
REQ-028 wb_cyc SHALL stay high continuously from first stb to final ack; wb_stb SHALL never be high without wb_cyc; wb_we constant for whole cycle.
REQ-029 Timeout counter SHALL clear on command accept and on each counted ack, increment each cycle in ISSUE/DRAIN; on reaching TIMEOUT: wb_cyc=0, wb_stb=0, state IDLE, one rsp_valid with rsp_err=1, rsp_last=1, rsp_data=0.
REQ-030 Ack and timeout in the same cycle: ack SHALL win (counter cleared, no abort).
REQ-031 rsp_valid, rsp_last, rsp_err SHALL be low in all cycles other than those defined above.

Reset
REQ-032 rst SHALL, from the next edge, force state IDLE, wb_cyc=0, wb_stb=0, wb_we=0, rsp_valid=0, rsp_last=0, rsp_err=0, outstanding=0, issued=0, timeout counter=0; wb_addr, wb_data_w, rsp_data=0.
REQ-033 rst mid-burst SHALL abandon the burst with no response; acks arriving after reset SHALL be ignored per REQ-024.
REQ-034 All registers SHALL have matching initial values for formal use.

Verification
REQ-035 Single read: addr 0x100, len 0, ack with data 0xDEADBEEF two cycles after stb -> one rsp_valid, rsp_data 0xDEADBEEF, rsp_last=1, cmd_ready high same cycle.
REQ-036 Write burst: addr 0x0, data 0x10, len 3, no stall, ack 1 cycle later -> wb_addr 0x0,0x4,0x8,0xC with data 0x10..0x13; 4 responses, last with rsp_last.
REQ-037 Stall: len 2, wb_stall high 3 cycles on beat 1 -> wb_addr/wb_data_w hold through stall; beats still issue in order, exactly 3 responses.
REQ-038 Outstanding limit (MAX_OUTSTANDING=2): len 7, acks withheld -> stb drops after 2 beats, resumes one beat per ack; outstanding never exceeds 2.
REQ-039 Timeout (TIMEOUT=8): len 1, no acks -> 8 cycles after last counter clear, wb_cyc falls, one response rsp_err=1, rsp_last=1.
REQ-040 Reset mid-burst after 2 of 4 beats, then stray ack -> wb_cyc=0 next cycle, no rsp_valid, next command starts cleanly at its own address.
